// File: rtl/router_pkg.sv
// Shared definitions for the mesh router.
// Contents:
//   DATA_WIDTH, NUM_IN    - packet width and number of router input ports
//   PORT_* / PORT_*_OH    - port indices and their one-hot encodings; the same
//                           one-hot values select the routing stage direction
//   HDR_*                 - packet header field bit positions
//   state_t               - output register occupancy state
package router_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_IN     = 5;

  localparam int PORT_L  = 0;
  localparam int PORT_R  = 1;
  localparam int PORT_U  = 2;
  localparam int PORT_D  = 3;
  localparam int PORT_PE = 4;

  localparam logic [4:0] PORT_L_OH  = 5'b00001;
  localparam logic [4:0] PORT_R_OH  = 5'b00010;
  localparam logic [4:0] PORT_U_OH  = 5'b00100;
  localparam logic [4:0] PORT_D_OH  = 5'b01000;
  localparam logic [4:0] PORT_PE_OH = 5'b10000;

  // Header layout (most significant bits of the packet).
  localparam int HDR_DIR_X     = 62;
  localparam int HDR_DIR_Y     = 61;
  localparam int HDR_HOP_MSB   = 60;
  localparam int HDR_HOP_LSB   = 57;
  localparam int HDR_SRC_X_MSB = 56;
  localparam int HDR_SRC_X_LSB = 53;
  localparam int HDR_SRC_Y_MSB = 52;
  localparam int HDR_SRC_Y_LSB = 49;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational five-way round-robin picker.
// Ports:
//   req[4:0] - request vector
//   ptr[2:0] - index (0..4) with highest priority this cycle
//   gnt[4:0] - one-hot winner (0 when no request)
//   idx[2:0] - encoded winner index
//   any      - at least one request is present
// The search order is ptr, ptr+1, ... wrapping modulo 5.
module rr_arbiter5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt,
  output logic [2:0] idx,
  output logic       any
);

  logic [4:0] w_rot;  // req rotated so that bit0 is the ptr position
  logic [2:0] w_off;  // offset of the first set bit in w_rot

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  always_comb begin
    case (ptr)
      3'd1:    w_rot = {req[0],   req[4:1]};
      3'd2:    w_rot = {req[1:0], req[4:2]};
      3'd3:    w_rot = {req[2:0], req[4:3]};
      3'd4:    w_rot = {req[3:0], req[4]};
      default: w_rot = req;
    endcase
  end

  always_comb begin
    w_off = 3'd0;
    any   = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 3'(k);
        any   = 1'b1;
      end
    end
  end

  assign idx = wrap5({1'b0, ptr} + {1'b0, w_off});

  always_comb begin
    gnt = '0;
    for (int i = 0; i < 5; i++) begin
      gnt[i] = any && (idx == 3'(i));
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port arbiter of the mesh router.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   reqIn        - requests from the five inputs (bit0=L .. bit4=PE)
//   dataIn       - packets, slice i = dataIn[i*DATA_WIDTH +: DATA_WIDTH]
//   grantOut     - one-hot grant pulse, same cycle as the winning request
//   outValid     - output register holds a packet
//   outData      - packet presented downstream
//   outReady     - downstream accepts outData this cycle
//   pktCount     - packets handed downstream since reset (wrapping)
//   dbgState     - current occupancy state
// Handshake: a transfer happens on every rising edge where valid and ready
// are both high; the producer keeps valid and data stable until that edge,
// and ready while valid is low has no effect. The same rule governs the
// reqIn/grantOut pair: a request stays asserted with stable data until the
// cycle in which it is granted.
module output_port_arbiter #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int NUM_IN     = router_pkg::NUM_IN,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_IN-1:0]            reqIn,
  input  logic [NUM_IN*DATA_WIDTH-1:0] dataIn,
  output logic [NUM_IN-1:0]            grantOut,
  output logic                         outValid,
  output logic [DATA_WIDTH-1:0]        outData,
  input  logic                         outReady,
  output logic [CNT_WIDTH-1:0]         pktCount,
  output router_pkg::state_t           dbgState
);
  import router_pkg::*;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_ptr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [NUM_IN-1:0]     w_gnt;
  logic [2:0]            w_idx;
  logic                  w_any;
  logic                  w_drain;
  logic                  w_can_accept;
  logic                  w_grant;
  logic [2:0]            w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_win_data;

  rr_arbiter5 u_rr (
    .req (reqIn),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  assign outValid     = (r_state == ST_FULL);
  assign w_drain      = outValid & outReady;
  // A slot is free when empty, or when the held packet leaves this edge.
  assign w_can_accept = (r_state == ST_EMPTY) | w_drain;
  assign w_grant      = w_can_accept & w_any;
  assign w_ptr_nxt    = (w_idx == 3'd4) ? 3'd0 : w_idx + 3'd1;

  // reset_n gates the pulse so nothing pops while the port is held in reset.
  assign grantOut = w_gnt & {NUM_IN{w_grant & reset_n}};

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt[i]) w_win_data = dataIn[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_grant)      w_state_nxt = ST_FULL;
        else if (w_drain) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_ptr  <= 3'd0;
      r_cnt  <= '0;
    end else begin
      // On a drain without refill outData keeps its stale value.
      if (w_grant) begin
        r_data <= w_win_data;
        r_ptr  <= w_ptr_nxt;
      end
      if (w_drain) r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign outData  = r_data;
  assign pktCount = r_cnt;
  assign dbgState = r_state;

endmodule
